// File: rtl/shift_issue.sv
// Shift issue unit: request FIFO feeding a two-register pipeline around an external left shifter.
// Latency: 2 edges minimum from accept to res_valid; one result per cycle sustained.
// Backpressure: res_ready low holds S2 and stalls S1 and the FIFO; req_ready drops when the FIFO is full.
module shift_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_data,
  input  logic [5:0]               req_amt,
  input  logic [1:0]               req_op,
  input  logic [3:0]               req_tag,
  output logic [63:0]              sh_in,
  output logic [5:0]               sh_amt,
  input  logic [63:0]              sh_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [63:0]              res_data,
  output logic [3:0]               res_tag,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  amt;
    logic [1:0]  op;
    logic [3:0]  tag;
  } req_t;

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          live_q;

  logic          s1_vld_q, s1_vld_d;
  logic [63:0]   s1_in_q, s1_in_d;
  logic [5:0]    s1_amt_q, s1_amt_d;
  logic [1:0]    s1_op_q, s1_op_d;
  logic [3:0]    s1_tag_q, s1_tag_d;
  logic          s1_sign_q, s1_sign_d;

  logic          s2_vld_q, s2_vld_d;
  logic [63:0]   s2_data_q, s2_data_d;
  logic [3:0]    s2_tag_q, s2_tag_d;
  logic          s2_err_q, s2_err_d;

  req_t          head;
  req_t          req_in;
  logic          push, pop, s1_adv;
  logic [63:0]   rev_res, sra_mask, s2_in;

  // live_q keeps req_ready low while in reset and raises it on the first edge after release
  assign req_ready  = live_q && (count_q < DEPTH_C);
  assign fifo_count = count_q;
  assign sh_in      = s1_in_q;
  assign sh_amt     = s1_amt_q;
  assign res_valid  = s2_vld_q;
  assign res_data   = s2_data_q;
  assign res_tag    = s2_tag_q;
  assign res_err    = s2_err_q;

  assign head   = mem_q[rd_ptr_q];
  assign req_in = '{data: req_data, amt: req_amt, op: req_op, tag: req_tag};
  assign push   = req_valid && req_ready && !flush;
  assign s1_adv = !s2_vld_q || res_ready;
  assign pop    = (count_q != '0) && (!s1_vld_q || s1_adv);

  // Right shifts run through the left shifter on a reversed operand; SRA then fills the vacated top bits with the sign
  assign rev_res  = rev64(sh_result);
  assign sra_mask = ~({64{1'b1}} >> s1_amt_q);

  // Result selection for the value entering S2
  always_comb begin
    s2_in = sh_result;
    case (s1_op_q)
      OP_SRL:  s2_in = rev_res;
      OP_SRA:  s2_in = s1_sign_q ? (rev_res | sra_mask) : rev_res;
      default: s2_in = sh_result;
    endcase
  end

  // Next-state for FIFO pointers, occupancy and both pipeline stages; flush wins over everything
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    s1_vld_d  = s1_vld_q;
    s1_in_d   = s1_in_q;
    s1_amt_d  = s1_amt_q;
    s1_op_d   = s1_op_q;
    s1_tag_d  = s1_tag_q;
    s1_sign_d = s1_sign_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    s2_err_d  = s2_err_q;

    // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0 naturally
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);

    if (s1_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_data_d = s2_in;
        s2_tag_d  = s1_tag_q;
        s2_err_d  = (s1_op_q == OP_RSV);
      end
    end

    if (pop) begin
      s1_vld_d  = 1'b1;
      s1_in_d   = (head.op == OP_SRL || head.op == OP_SRA) ? rev64(head.data) : head.data;
      s1_amt_d  = head.amt;
      s1_op_d   = head.op;
      s1_tag_d  = head.tag;
      s1_sign_d = head.data[63];
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  // FIFO storage: payload only, validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_in;
  end

  // Control and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_in_q   <= '0;
      s1_amt_q  <= '0;
      s1_op_q   <= OP_SLL;
      s1_tag_q  <= '0;
      s1_sign_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      live_q    <= 1'b1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s1_vld_q  <= s1_vld_d;
      s1_in_q   <= s1_in_d;
      s1_amt_q  <= s1_amt_d;
      s1_op_q   <= s1_op_d;
      s1_tag_q  <= s1_tag_d;
      s1_sign_q <= s1_sign_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
      s2_err_q  <= s2_err_d;
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Bench for shift_issue: directed vector table, stall/flush/reset sequences, randomized traffic vs a queue model.
module tb_shift_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_data = '0;
  logic [5:0]  req_amt = '0;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_tag = '0;
  logic [63:0] sh_in;
  logic [5:0]  sh_amt;
  logic [63:0] sh_result;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic [3:0]  res_tag;
  logic        res_err;
  logic [2:0]  fifo_count;

  shift_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amt(req_amt), .req_op(req_op), .req_tag(req_tag),
    .sh_in(sh_in), .sh_amt(sh_amt), .sh_result(sh_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .fifo_count(fifo_count)
  );

  // external left shifter
  assign sh_result = sh_in << sh_amt;

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  amt;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  exp_t q[$];
  logic last_acc;
  vec_t vecs[9];

  function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] a, input logic [1:0] op);
    case (op)
      2'd1:    return d >> a;
      2'd2:    return 64'($signed(d) >>> a);
      default: return d << a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: sample handshakes before the edge, update the model after it
  task automatic tick();
    logic acc, ret, fl;
    logic [63:0] d;
    logic [3:0] t;
    logic er;
    exp_t ne, e;
    acc = req_valid && req_ready;
    ret = res_valid && res_ready;
    fl  = flush;
    d = res_data; t = res_tag; er = res_err;
    ne.data = ref_shift(req_data, req_amt, req_op);
    ne.tag  = req_tag;
    ne.err  = (req_op == 2'd3);
    @(posedge clk); #1;
    last_acc = acc;
    if (ret) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got tag %h expected no result", t);
      end else begin
        e = q.pop_front();
        chk("sb_data", d, e.data);
        chk("sb_tag", 64'(t), 64'(e.tag));
        chk("sb_err", 64'(er), 64'(e.err));
      end
    end
    if (fl) q.delete();
    else if (acc) q.push_back(ne);
  endtask

  initial begin
    int n, got, accepted;
    logic seen;

    vecs[0] = '{64'h1, 6'd63, 2'd0, 4'd3, 64'h8000_0000_0000_0000, 1'b0};
    vecs[1] = '{64'h8000_0000_0000_0000, 6'd4, 2'd2, 4'd5, 64'hF800_0000_0000_0000, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 6'd4, 2'd1, 4'd6, 64'h0800_0000_0000_0000, 1'b0};
    vecs[3] = '{64'hF, 6'd1, 2'd3, 4'd7, 64'h1E, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0001, 6'd0, 2'd2, 4'd8, 64'h8000_0000_0000_0001, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 2'd1, 4'd9, 64'h1, 1'b0};
    vecs[6] = '{64'h7000_0000_0000_0000, 6'd60, 2'd2, 4'd10, 64'h7, 1'b0};
    vecs[7] = '{64'hFFFF_0000_0000_0000, 6'd63, 2'd2, 4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[8] = '{64'h1234_5678_9ABC_DEF0, 6'd4, 2'd0, 4'd12, 64'h2345_6789_ABCD_EF00, 1'b0};

    // reset state
    #2;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_sh_in", sh_in, 64'd0);
    chk("rst_sh_amt", 64'(sh_amt), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // vector table: isolated requests, latency and value
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_data = vecs[i].data; req_amt = vecs[i].amt;
      req_op = vecs[i].op; req_tag = vecs[i].tag;
      tick();
      chk("vec_accept", 64'(last_acc), 64'd1);
      req_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 8) begin tick(); n++; end
      chk("vec_latency", 64'(n), 64'd2);
      chk("vec_data", res_data, vecs[i].exp);
      chk("vec_tag", 64'(res_tag), 64'(vecs[i].tag));
      chk("vec_err", 64'(res_err), 64'(vecs[i].err));
      tick();
    end

    // stall: 6 pushes with the consumer blocked
    res_ready = 1'b0;
    accepted = 0; n = 0;
    while (accepted < 6 && n < 30) begin
      req_valid = 1'b1;
      req_data = {$urandom, $urandom}; req_amt = 6'($urandom);
      req_op = 2'($urandom_range(0, 2)); req_tag = 4'(accepted);
      tick();
      if (last_acc) accepted++;
      n++;
    end
    req_valid = 1'b0;
    chk("stall_accepted", 64'(accepted), 64'd6);
    chk("stall_count", 64'(fifo_count), 64'd4);
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    chk("stall_res_valid", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    got = 0; n = 0;
    while (got < 6 && n < 30) begin
      if (res_valid) begin
        chk("stall_tag_order", 64'(res_tag), 64'(got));
        got++;
      end
      tick();
      n++;
    end
    chk("stall_results", 64'(got), 64'd6);

    // flush with S1/S2 full, 3 queued and a concurrent push
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_data = {$urandom, $urandom}; req_amt = 6'($urandom);
      req_op = 2'd0; req_tag = 4'(8 + i);
      tick();
    end
    chk("preflush_count", 64'(fifo_count), 64'd3);
    flush = 1'b1;
    req_tag = 4'd15;
    tick();
    chk("flush_handshake", 64'(last_acc), 64'd1);
    chk("flush_count", 64'(fifo_count), 64'd0);
    chk("flush_res_valid", 64'(res_valid), 64'd0);
    flush = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    chk("flush_count_after", 64'(fifo_count), 64'd0);

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      res_ready = ($urandom_range(0, 9) < 7);
      req_data  = {$urandom, $urandom};
      req_amt   = 6'($urandom);
      req_op    = 2'($urandom);
      req_tag   = 4'($urandom);
      tick();
    end
    req_valid = 1'b0; res_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin tick(); n++; end
    chk("random_drain", 64'(q.size()), 64'd0);

    // reset mid-stream
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_data = {$urandom, $urandom}; req_amt = 6'($urandom);
      req_op = 2'($urandom); req_tag = 4'($urandom);
      tick();
    end
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_res_data", res_data, 64'd0);
    chk("arst_res_tag", 64'(res_tag), 64'd0);
    chk("arst_res_err", 64'(res_err), 64'd0);
    chk("arst_sh_in", sh_in, 64'd0);
    chk("arst_sh_amt", 64'(sh_amt), 64'd0);
    req_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready_after", 64'(req_ready), 64'd1);
    res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("arst_no_stale", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
